// File: rtl/pc_channel_sequencer_if.sv
// Handshake and mux-bus bundle between the point-triple source, the channel
// sequencer and the downstream one-hot 3-to-1 mux.
interface pc_channel_sequencer_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_n;
  logic [DATA_W-1:0] in_k;
  logic [DATA_W-1:0] in_m;
  logic [DATA_W-1:0] mux_inN;
  logic [DATA_W-1:0] mux_inK;
  logic [DATA_W-1:0] mux_inM;
  logic [2:0]        mux_sel;
  logic              out_valid;
  logic              out_last;
  logic              out_ready;

  modport master (
    input  in_valid, in_n, in_k, in_m, out_ready,
    output in_ready, mux_inN, mux_inK, mux_inM, mux_sel, out_valid, out_last
  );

  modport slave (
    output in_valid, in_n, in_k, in_m, out_ready,
    input  in_ready, mux_inN, mux_inK, mux_inM, mux_sel, out_valid, out_last
  );
endinterface

// File: rtl/pc_channel_sequencer.sv
// Accepts one N/K/M byte triple per handshake, holds it on the mux inputs and
// walks a one-hot select N -> K -> M under downstream back-pressure.
module pc_channel_sequencer #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  pc_channel_sequencer_if.master bus,
  output logic [CNT_W-1:0]     triple_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND_N = 2'd1,
    SEND_K = 2'd2,
    SEND_M = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] n_q, n_d, k_q, k_d, m_q, m_d;
  logic [2:0]        sel_q, sel_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              in_ready_s;
  logic              accept_s;

  // Upstream may hand over a triple when idle, or in the M beat that is completing now.
  always_comb begin
    in_ready_s = 1'b0;
    if (rst) begin
      in_ready_s = 1'b0;
    end else begin
      case (state_q)
        IDLE:    in_ready_s = 1'b1;
        SEND_M:  in_ready_s = bus.out_ready;
        default: in_ready_s = 1'b0;
      endcase
    end
  end

  assign accept_s = bus.in_valid & in_ready_s;

  // Next state, data capture and counter update; outputs are decoded from the next state.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    k_d     = k_q;
    m_d     = m_q;
    count_d = count_q;
    sel_d   = 3'b000;
    valid_d = 1'b0;
    last_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept_s) begin
          n_d     = bus.in_n;
          k_d     = bus.in_k;
          m_d     = bus.in_m;
          state_d = SEND_N;
        end else begin
          state_d = IDLE;
        end
      end
      SEND_N: begin
        if (bus.out_ready) begin
          state_d = SEND_K;
        end else begin
          state_d = SEND_N;
        end
      end
      SEND_K: begin
        if (bus.out_ready) begin
          state_d = SEND_M;
        end else begin
          state_d = SEND_K;
        end
      end
      SEND_M: begin
        if (bus.out_ready) begin
          count_d = count_q + CNT_W'(1);
          if (accept_s) begin
            n_d     = bus.in_n;
            k_d     = bus.in_k;
            m_d     = bus.in_m;
            state_d = SEND_N;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = SEND_M;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A stalled beat keeps state_d == state_q, so the decoded outputs hold too.
    case (state_d)
      IDLE: begin
        sel_d   = 3'b000;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
      SEND_N: begin
        sel_d   = 3'b001;
        valid_d = 1'b1;
        last_d  = 1'b0;
      end
      SEND_K: begin
        sel_d   = 3'b010;
        valid_d = 1'b1;
        last_d  = 1'b0;
      end
      SEND_M: begin
        sel_d   = 3'b100;
        valid_d = 1'b1;
        last_d  = 1'b1;
      end
      default: begin
        sel_d   = 3'b000;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase
  end

  // State, data and registered output flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      n_q     <= {DATA_W{1'b0}};
      k_q     <= {DATA_W{1'b0}};
      m_q     <= {DATA_W{1'b0}};
      sel_q   <= 3'b000;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      count_q <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      k_q     <= k_d;
      m_q     <= m_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      count_q <= count_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.mux_inN   = n_q;
  assign bus.mux_inK   = k_q;
  assign bus.mux_inM   = m_q;
  assign bus.mux_sel   = sel_q;
  assign bus.out_valid = valid_q;
  assign bus.out_last  = last_q;
  assign triple_count  = count_q;

endmodule

// File: tb/tb_pc_channel_sequencer.sv
// Self-checking bench: directed scenarios plus random traffic compared each
// cycle against a byte-queue reference model of the sequencer.
module tb_pc_channel_sequencer;
  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] triple_count;

  always #5 clk = ~clk;

  pc_channel_sequencer_if #(.DATA_W(DW)) bus ();

  pc_channel_sequencer #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .triple_count (triple_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: the bytes still owed downstream, the last accepted triple
  // and the completed-triple total.
  logic [DW-1:0] q[$];
  logic [DW-1:0] cur_n = '0, cur_k = '0, cur_m = '0;
  int            mcount = 0;
  bit            acc_seen = 1'b0;
  bit            rdy_now;
  bit            check_en = 1'b0;

  function automatic bit model_in_ready();
    return !rst && (q.size() == 0 || (q.size() == 1 && bus.out_ready));
  endfunction

  function automatic logic [2:0] model_sel(input int sz);
    case (sz)
      3:       return 3'b001;
      2:       return 3'b010;
      1:       return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  always @(posedge clk) begin
    acc_seen = 1'b0;
    if (rst) begin
      q.delete();
      cur_n  = '0;
      cur_k  = '0;
      cur_m  = '0;
      mcount = 0;
    end else begin
      rdy_now = model_in_ready();
      if (q.size() > 0 && bus.out_ready) begin
        void'(q.pop_front());
        if (q.size() == 0) mcount = (mcount + 1) % (1 << CW);
      end
      if (rdy_now && bus.in_valid) begin
        q.push_back(bus.in_n);
        q.push_back(bus.in_k);
        q.push_back(bus.in_m);
        cur_n    = bus.in_n;
        cur_k    = bus.in_k;
        cur_m    = bus.in_m;
        acc_seen = 1'b1;
      end
    end
  end

  logic [DW-1:0] muxed;
  bit            legal;

  always @(negedge clk) begin
    if (check_en) begin
      muxed = (bus.mux_sel == 3'b001) ? bus.mux_inN :
              (bus.mux_sel == 3'b010) ? bus.mux_inK :
              (bus.mux_sel == 3'b100) ? bus.mux_inM : '0;
      legal = (bus.mux_sel inside {3'b000, 3'b001, 3'b010, 3'b100}) &&
              (bus.out_valid == (bus.mux_sel != 3'b000));
      check_eq("sel_legal", 32'(legal), 32'd1);
      check_eq("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
      check_eq("out_last",  32'(bus.out_last),  32'(q.size() == 1));
      check_eq("mux_sel",   32'(bus.mux_sel),   32'(model_sel(q.size())));
      check_eq("in_ready",  32'(bus.in_ready),  32'(model_in_ready()));
      check_eq("mux_inN",   32'(bus.mux_inN),   32'(cur_n));
      check_eq("mux_inK",   32'(bus.mux_inK),   32'(cur_k));
      check_eq("mux_inM",   32'(bus.mux_inM),   32'(cur_m));
      check_eq("count",     32'(triple_count),  32'(mcount));
      if (q.size() != 0) check_eq("beat_byte", 32'(muxed), 32'(q[0]));
    end
  end

  // Stimulus helpers.
  logic [DW-1:0] t_n, t_k, t_m;
  bit            pending;
  int            cyc;

  task automatic tick();
    @(posedge clk);
    #1;
    if (acc_seen) begin
      pending      = 1'b0;
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic stream(input int n, input bit rnd, input int max_cycles, output int cycles);
    int remaining;
    remaining = n;
    cycles    = 0;
    pending   = 1'b0;
    while ((remaining > 0 || pending || q.size() > 0) && cycles < max_cycles) begin
      if (!pending && remaining > 0 && (!rnd || $urandom_range(0, 2) != 0)) begin
        pending = 1'b1;
        remaining--;
        if (rnd) begin
          t_n = DW'($urandom);
          t_k = DW'($urandom);
          t_m = DW'($urandom);
        end else if (remaining != n - 1) begin
          t_n = t_n + 8'd1;
          t_k = t_k + 8'd1;
          t_m = t_m + 8'd1;
        end
      end
      bus.in_valid  = pending;
      bus.in_n      = t_n;
      bus.in_k      = t_k;
      bus.in_m      = t_m;
      bus.out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      tick();
      cycles++;
    end
    check_eq("stream_done", 32'(cycles < max_cycles), 32'd1);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  task automatic send_one(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c);
    int k;
    bus.in_n     = a;
    bus.in_k     = b;
    bus.in_m     = c;
    bus.in_valid = 1'b1;
    pending      = 1'b1;
    k            = 0;
    while (pending && k < 20) begin
      tick();
      k++;
    end
    check_eq("accept_seen", 32'(pending), 32'd0);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_n      = '0;
    bus.in_k      = '0;
    bus.in_m      = '0;
    bus.out_ready = 1'b1;
    tick();
    check_en = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rst_count", 32'(triple_count), 32'd0);

    // Reset in the middle of a triple, then a normal triple.
    send_one(8'h5A, 8'h6B, 8'h7C);
    tick();
    check_eq("mid_sel_k", 32'(bus.mux_sel), 32'h2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("mid_rst_sel",   32'(bus.mux_sel),   32'h0);
    check_eq("mid_rst_valid", 32'(bus.out_valid), 32'h0);
    check_eq("mid_rst_count", 32'(triple_count),  32'h0);
    t_n = 8'h11; t_k = 8'h22; t_m = 8'h33;
    stream(1, 1'b0, 20, cyc);
    check_eq("t1_cycles", 32'(cyc), 32'd4);
    check_eq("t1_count",  32'(triple_count), 32'd1);
    check_eq("t1_idle",   32'(bus.mux_sel),  32'h0);

    // Back-to-back: 1 acceptance cycle plus 12 beats with no bubble.
    t_n = 8'h40; t_k = 8'h50; t_m = 8'h60;
    stream(4, 1'b0, 50, cyc);
    check_eq("b2b_cycles", 32'(cyc), 32'd13);
    check_eq("b2b_count",  32'(triple_count), 32'd5);

    // Back-pressure for 5 cycles during the K beat.
    send_one(8'hA0, 8'hB1, 8'hC2);
    tick();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("stall_sel",  32'(bus.mux_sel),  32'h2);
      check_eq("stall_byte", 32'(bus.mux_inK),  32'hB1);
      check_eq("stall_rdy",  32'(bus.in_ready), 32'h0);
    end
    bus.out_ready = 1'b1;
    tick();
    check_eq("resume_sel",  32'(bus.mux_sel), 32'h4);
    check_eq("resume_byte", 32'(bus.mux_inM), 32'hC2);
    tick();
    check_eq("stall_count", 32'(triple_count), 32'd6);

    // Counter wrap for a 4-bit counter.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    t_n = 8'h01; t_k = 8'h02; t_m = 8'h03;
    stream(15, 1'b0, 100, cyc);
    check_eq("wrap_15", 32'(triple_count), 32'd15);
    stream(1, 1'b0, 20, cyc);
    check_eq("wrap_16", 32'(triple_count), 32'd0);
    stream(1, 1'b0, 20, cyc);
    check_eq("wrap_17", 32'(triple_count), 32'd1);

    // Random traffic with random back-pressure.
    stream(80, 1'b1, 4000, cyc);

    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
